kl8e_console_tty: RTL and testbench

- Console teletype controller (KL8E-style): keyboard device 03 and printer device 04.
- Sits directly downstream of the IOT base decoder. Consumes its IOT603x and IOT604x strobes plus IR[2:0], and produces skip, AC-clear and AC-OR responses to the CPU.
- Toward the serial side it exchanges bytes with an external UART over valid/ready handshakes.
- Holds the keyboard and printer flags, the character buffers and the interrupt enable.

---
 rtl/pdp8_iot_pkg.sv | 17 +
 rtl/kl8e_tx_chan.sv | 46 ++++
 rtl/kl8e_console_tty.sv | 119 +++++++++++
 tb/tb_kl8e_console_tty.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_iot_pkg.sv
// Shared IOT decode constants for PDP-8 peripheral controllers: IR[2:0]
// function-bit positions, their one-hot masks, and device codes.
package pdp8_iot_pkg;

  localparam int FN_SKIP = 0;
  localparam int FN_CLR  = 1;
  localparam int FN_XFER = 2;

  localparam int DEV_KBD = 3;
  localparam int DEV_PRT = 4;

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_SKIP = 3'b001 << FN_SKIP;
  localparam logic [2:0] F_CLR  = 3'b001 << FN_CLR;
  localparam logic [2:0] F_XFER = 3'b001 << FN_XFER;

endpackage

// File: rtl/kl8e_tx_chan.sv
// Printer channel: transmit buffer, TX valid/ready handshake and the
// printer flag (TF), which is set by a completed transfer or by TFL.
module kl8e_tx_chan #(
  parameter int CHAR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [CHAR_W-1:0] ld_data,
  input  logic              tf_set,
  input  logic              tf_clr,
  output logic [CHAR_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tf
);

  logic [CHAR_W-1:0] tbuf;
  logic              tx_done;

  assign tx_done = tx_valid & tx_ready;
  assign tx_data = tbuf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbuf     <= '0;
      tx_valid <= 1'b0;
      tf       <= 1'b0;
    end else begin
      // A load during a completing handshake starts the next character at once.
      if (load) begin
        tbuf     <= ld_data;
        tx_valid <= 1'b1;
      end else if (tx_done) begin
        tx_valid <= 1'b0;
      end
      // Set beats clear so a finished character is never lost.
      if (tx_done || tf_set) begin
        tf <= 1'b1;
      end else if (tf_clr) begin
        tf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/kl8e_console_tty.sv
// KL8E console teletype: keyboard (device 03) and printer (device 04)
// IOT responses, flags, interrupt enable and UART byte handshakes.
module kl8e_console_tty
  import pdp8_iot_pkg::*;
#(
  parameter int AC_W   = 12,
  parameter int CHAR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IOT603x,
  input  logic              IOT604x,
  input  logic [2:0]        IR_LO,
  input  logic              CK_3,
  input  logic [AC_W-1:0]   AC,
  output logic              SKIP,
  output logic              CLR_AC,
  output logic [AC_W-1:0]   AC_OR,
  output logic              IRQ,
  input  logic [CHAR_W-1:0] RX_DATA,
  input  logic              RX_VALID,
  output logic              RX_READY,
  output logic [CHAR_W-1:0] TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY
);

  logic              kf;
  logic              ie;
  logic              tf;
  logic [CHAR_W-1:0] kbuf;
  logic              k_commit;
  logic              p_commit;
  logic              kf_clr;
  logic              ie_ld;
  logic              rx_acc;
  logic              tf_set;
  logic              tf_clr;
  logic              tx_load;
  logic              unused_ac;

  assign unused_ac = ^AC;

  assign k_commit = CK_3 & IOT603x;
  assign p_commit = CK_3 & IOT604x;

  assign kf_clr  = k_commit & ((IR_LO == F_NONE) || (IR_LO == F_CLR) ||
                               (IR_LO == (F_CLR | F_XFER)));
  assign ie_ld   = k_commit & (IR_LO == (F_SKIP | F_XFER));
  assign tf_set  = p_commit & (IR_LO == F_NONE);
  assign tf_clr  = p_commit & ((IR_LO == F_CLR) || (IR_LO == (F_CLR | F_XFER)));
  assign tx_load = p_commit & ((IR_LO == F_XFER) || (IR_LO == (F_CLR | F_XFER)));

  assign RX_READY = ~kf;
  assign rx_acc   = RX_VALID & ~kf;
  assign IRQ      = ie & (kf | tf);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      kf   <= 1'b0;
      ie   <= 1'b1;
      kbuf <= '0;
    end else begin
      if (rx_acc) begin
        kbuf <= RX_DATA;
      end
      // An arriving character outranks a same-cycle flag clear.
      if (rx_acc) begin
        kf <= 1'b1;
      end else if (kf_clr) begin
        kf <= 1'b0;
      end
      if (ie_ld) begin
        ie <= AC[0];
      end
    end
  end

  always_comb begin
    SKIP   = 1'b0;
    CLR_AC = 1'b0;
    AC_OR  = '0;
    if (IOT603x) begin
      case (IR_LO)
        F_SKIP:          SKIP   = kf;
        F_CLR:           CLR_AC = 1'b1;
        F_XFER:          AC_OR  = AC_W'(kbuf);
        (F_CLR | F_XFER): begin
          CLR_AC = 1'b1;
          AC_OR  = AC_W'(kbuf);
        end
        default: ;
      endcase
    end
    if (IOT604x) begin
      case (IR_LO)
        F_SKIP:           SKIP = tf;
        (F_SKIP | F_XFER): SKIP = IRQ;
        default: ;
      endcase
    end
  end

  kl8e_tx_chan #(
    .CHAR_W (CHAR_W)
  ) u_tx_chan (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load     (tx_load),
    .ld_data  (AC[CHAR_W-1:0]),
    .tf_set   (tf_set),
    .tf_clr   (tf_clr),
    .tx_data  (TX_DATA),
    .tx_valid (TX_VALID),
    .tx_ready (TX_READY),
    .tf       (tf)
  );

endmodule

// File: tb/tb_kl8e_console_tty.sv
// Directed bench for kl8e_console_tty: IOT responses, UART handshakes,
// flag set/clear collisions, interrupt enable and asynchronous reset.
module tb_kl8e_console_tty;
  import pdp8_iot_pkg::*;

  logic        CLK;
  logic        RESET_N;
  logic        IOT603x;
  logic        IOT604x;
  logic [2:0]  IR_LO;
  logic        CK_3;
  logic [11:0] AC;
  logic        SKIP;
  logic        CLR_AC;
  logic [11:0] AC_OR;
  logic        IRQ;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;

  int total = 0;
  int bad   = 0;

  kl8e_console_tty #(.AC_W(12), .CHAR_W(8)) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .IOT603x  (IOT603x),
    .IOT604x  (IOT604x),
    .IR_LO    (IR_LO),
    .CK_3     (CK_3),
    .AC       (AC),
    .SKIP     (SKIP),
    .CLR_AC   (CLR_AC),
    .AC_OR    (AC_OR),
    .IRQ      (IRQ),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One committed IOT: strobe and CK_3 held across a single rising edge.
  task automatic exec(input int dev, input logic [2:0] fn, input logic [11:0] ac);
    IOT603x = (dev == DEV_KBD);
    IOT604x = (dev == DEV_PRT);
    IR_LO   = fn;
    AC      = ac;
    CK_3    = 1'b1;
    tick();
    CK_3    = 1'b0;
    IOT603x = 1'b0;
    IOT604x = 1'b0;
  endtask

  task automatic chk_skip(input string tag, input int dev, input logic [2:0] fn, input logic exp);
    IOT603x = (dev == DEV_KBD);
    IOT604x = (dev == DEV_PRT);
    IR_LO   = fn;
    #1;
    chk(tag, 32'(SKIP), 32'(exp));
    IOT603x = 1'b0;
    IOT604x = 1'b0;
    #1;
  endtask

  task automatic rx_char(input logic [7:0] c);
    RX_DATA  = c;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; IOT603x = 1'b0; IOT604x = 1'b0; IR_LO = 3'd0; CK_3 = 1'b0;
    AC = 12'h000; RX_DATA = 8'h00; RX_VALID = 1'b0; TX_READY = 1'b0;
    #3;
    chk("rst_skip", 32'(SKIP), 32'd0);
    chk("rst_clr_ac", 32'(CLR_AC), 32'd0);
    chk("rst_ac_or", 32'(AC_OR), 32'd0);
    chk("rst_irq", 32'(IRQ), 32'd0);
    chk("rst_rx_ready", 32'(RX_READY), 32'd1);
    chk("rst_tx_valid", 32'(TX_VALID), 32'd0);
    tick(); tick();
    RESET_N = 1'b1;
    tick();

    // Keyboard receive, KSF, KRB
    rx_char(8'h41);
    chk("rx_ready_kf1", 32'(RX_READY), 32'd0);
    chk("irq_kf", 32'(IRQ), 32'd1);
    chk_skip("ksf_1", DEV_KBD, 3'd1, 1'b1);
    IOT603x = 1'b1; IR_LO = 3'd6; #1;
    chk("krb_clr_ac", 32'(CLR_AC), 32'd1);
    chk("krb_ac_or", 32'(AC_OR), 32'h041);
    IOT603x = 1'b0;
    exec(DEV_KBD, 3'd6, 12'h000);
    chk("krb_kf_clr", 32'(RX_READY), 32'd1);
    chk("irq_idle", 32'(IRQ), 32'd0);
    chk_skip("ksf_0", DEV_KBD, 3'd1, 1'b0);

    // TLS then stalled UART, then handshake
    exec(DEV_PRT, 3'd6, 12'h0C5);
    chk("tls_valid", 32'(TX_VALID), 32'd1);
    chk("tls_data", 32'(TX_DATA), 32'hC5);
    repeat (5) tick();
    chk("stall_valid", 32'(TX_VALID), 32'd1);
    chk_skip("stall_tsf", DEV_PRT, 3'd1, 1'b0);
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    chk("hs_valid_drop", 32'(TX_VALID), 32'd0);
    chk_skip("hs_tsf", DEV_PRT, 3'd1, 1'b1);
    chk("hs_irq", 32'(IRQ), 32'd1);

    // Interrupt enable via KIE
    exec(DEV_PRT, 3'd2, 12'h000);
    exec(DEV_KBD, 3'd5, 12'h000);
    rx_char(8'h55);
    chk("ie0_irq", 32'(IRQ), 32'd0);
    chk_skip("ie0_tsk", DEV_PRT, 3'd5, 1'b0);
    IOT603x = 1'b1; IR_LO = 3'd4; #1;
    chk("krs_ac_or", 32'(AC_OR), 32'h055);
    chk("krs_no_clr", 32'(CLR_AC), 32'd0);
    IOT603x = 1'b0;
    exec(DEV_KBD, 3'd5, 12'h001);
    chk("ie1_irq", 32'(IRQ), 32'd1);
    chk_skip("ie1_tsk", DEV_PRT, 3'd5, 1'b1);
    exec(DEV_KBD, 3'd0, 12'h000);
    chk("kcf_kf_clr", 32'(RX_READY), 32'd1);

    // TX completion collides with TCF: set wins
    exec(DEV_PRT, 3'd4, 12'h0AA);
    TX_READY = 1'b1;
    exec(DEV_PRT, 3'd2, 12'h000);
    TX_READY = 1'b0;
    chk_skip("tcf_vs_hs_tf", DEV_PRT, 3'd1, 1'b1);
    chk("tcf_vs_hs_valid", 32'(TX_VALID), 32'd0);

    // RX accept collides with KCC: set wins
    RX_DATA = 8'h66; RX_VALID = 1'b1;
    exec(DEV_KBD, 3'd2, 12'h000);
    RX_VALID = 1'b0;
    chk("kcc_vs_rx_kf", 32'(RX_READY), 32'd0);
    IOT603x = 1'b1; IR_LO = 3'd4; #1;
    chk("kcc_vs_rx_kbuf", 32'(AC_OR), 32'h066);
    IOT603x = 1'b0;
    exec(DEV_KBD, 3'd0, 12'h000);
    exec(DEV_PRT, 3'd2, 12'h000);

    // Strobe without CK_3 changes nothing
    IOT604x = 1'b1; IR_LO = 3'd6; AC = 12'h0EE;
    tick();
    IOT604x = 1'b0;
    chk("no_ck3_valid", 32'(TX_VALID), 32'd0);

    // Overwrite of a pending character: last write wins, one transfer
    exec(DEV_PRT, 3'd4, 12'h0C5);
    exec(DEV_PRT, 3'd4, 12'h033);
    chk("ovw_valid", 32'(TX_VALID), 32'd1);
    chk("ovw_data", 32'(TX_DATA), 32'h33);
    TX_READY = 1'b1;
    tick();
    chk("ovw_hs_drop", 32'(TX_VALID), 32'd0);
    tick();
    TX_READY = 1'b0;
    chk("ovw_single", 32'(TX_VALID), 32'd0);
    exec(DEV_PRT, 3'd2, 12'h000);

    // TLS in the same cycle as a handshake: old completes, new loads
    exec(DEV_PRT, 3'd4, 12'h011);
    TX_READY = 1'b1;
    exec(DEV_PRT, 3'd6, 12'h022);
    TX_READY = 1'b0;
    chk("tls_hs_valid", 32'(TX_VALID), 32'd1);
    chk("tls_hs_data", 32'(TX_DATA), 32'h22);
    chk_skip("tls_hs_tf", DEV_PRT, 3'd1, 1'b1);

    // Asynchronous reset between edges while a character is pending
    rx_char(8'h77);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_tx_valid", 32'(TX_VALID), 32'd0);
    chk("arst_rx_ready", 32'(RX_READY), 32'd1);
    chk("arst_irq", 32'(IRQ), 32'd0);
    chk_skip("arst_tsf", DEV_PRT, 3'd1, 1'b0);
    tick();
    RESET_N = 1'b1;
    TX_READY = 1'b1;
    repeat (3) tick();
    TX_READY = 1'b0;
    chk_skip("post_rst_tsf", DEV_PRT, 3'd1, 1'b0);
    chk("post_rst_valid", 32'(TX_VALID), 32'd0);
    rx_char(8'h01);
    chk("post_rst_ie", 32'(IRQ), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
